alu_writeback_queue: RTL and testbench
======================================

Name: alu_writeback_queue

Overview:
- Downstream stage of the integer ALU. Captures each ALU result, its destination register index and its status flags (zero/neg/nan).
- Buffers results in a small FIFO and drains them one per cycle into the register-file write port when that port accepts.
- Holds the flags of the most recently accepted result for branch logic.
- Offers a combinational lookup of pending writes, so the operand-fetch stage can forward values not yet written back.

Parameters:
- DEPTH, 4, number of queue entries; power of two, >= 2.
- DATA_W, 32, result width; matches the ALU res width.
- REG_ADDR_W, 5, register index width (32 architectural registers; register 0 hard-wired to zero).

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  ALU result presented this cycle.
- in_ready  output  1  queue accepts a result this cycle.
- in_res  input  DATA_W  ALU result.
- in_rd  input  REG_ADDR_W  destination register index.
- in_zero  input  1  ALU zero flag for in_res.
- in_neg  input  1  ALU negative flag for in_res.
- in_nan  input  1  ALU nan / divide-by-zero flag for in_res.
- wb_valid  output  1  head entry is presented to the register file.
- wb_ready  input  1  register file consumes the head entry this cycle.
- wb_addr  output  REG_ADDR_W  head entry register index.
- wb_data  output  DATA_W  head entry data.
- flag_zero  output  1  zero flag of the last accepted result.
- flag_neg  output  1  neg flag of the last accepted result.
- flag_nan  output  1  nan flag of the last accepted result.
- lookup_addr  input  REG_ADDR_W  register index queried by operand fetch.
- lookup_hit  output  1  a queued entry targets lookup_addr.
- lookup_data  output  DATA_W  data of the youngest matching entry; 0 when no hit.
- count  output  clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (async assert, synchronous release):
  - Head/tail pointers and count = 0.
  - wb_valid = 0; flags = 0; lookup_hit = 0.
  - Entry contents don't-care; wb_addr and wb_data read as 0 while empty.
  - Reset mid-operation discards all pending entries; nothing is written back.
- Accept: in_valid && in_ready at a rising edge.
  - Flags always update to in_zero/in_neg/in_nan, whatever in_rd is.
  - If in_rd != 0: the entry is written at the tail and the tail pointer advances (wraps modulo DEPTH).
  - If in_rd == 0: result is accepted and dropped; no entry is stored.
- Drain: wb_valid && wb_ready at a rising edge pops the head and advances the head pointer (wraps modulo DEPTH).
- wb_valid = (count != 0). wb_addr and wb_data come directly from head storage.
- Latency: an accepted entry appears on wb_* the cycle after acceptance. There is no same-cycle bypass from in_* to wb_*, even when the queue is empty.
- in_ready = (count < DEPTH) || (wb_valid && wb_ready).
  - When full, a simultaneous pop frees the slot, so push is allowed that cycle.
- Count update:
  - Simultaneous stored push + pop: count unchanged; both pointers advance.
  - Push with rd == 0 + pop: count decrements.
- Full: in_ready low unless a pop occurs; in_valid held while in_ready is low is not accepted; flags unchanged.
- Empty: wb_valid = 0; wb_ready ignored; no pop.
- Lookup is combinational over occupied entries only.
  - Hit if any occupied entry has rd == lookup_addr and lookup_addr != 0.
  - lookup_data = youngest (closest to tail) matching entry.
  - An entry popped this cycle still counts as a hit until the clock edge.
  - The in_* port is not searched.
- Entries are written back strictly in acceptance order; no coalescing.

Test Plan:
- Reset then idle -> wb_valid=0, count=0, in_ready=1, flags=0, lookup_hit=0 for lookup_addr=5.
- Push res=0x0000002A rd=3 (zero=0) with wb_ready=0 -> next cycle wb_valid=1, wb_addr=3, wb_data=0x2A, count=1. Raise wb_ready -> popped; wb_valid=0 the following cycle.
- With wb_ready=0, push 4 entries (rd=1,2,3,4) -> count=4, in_ready=0. A 5th in_valid is held and not accepted. Set wb_ready=1 with in_valid still high -> pop rd=1 and push the 5th in the same cycle; count stays 4. Drain order 2,3,4,5th.
- Push rd=7 data 0x11, then rd=7 data 0x22, wb_ready=0 -> lookup_addr=7 gives hit=1, data=0x22. lookup_addr=0 gives hit=0.
- Push res=0 rd=0 zero=1 -> count unchanged, no writeback, flag_zero=1. Then push res=0xFFFFFFFF rd=9 neg=1 -> flag_zero=0, flag_neg=1.
- With 3 entries queued, assert rst mid-cycle -> count=0 and wb_valid=0 immediately (async); after release, no stale entry is written back.

Source files
------------

// File: rtl/alu_writeback_queue.sv
// alu_writeback_queue: buffers ALU results for register-file writeback with pending-write lookup
module alu_writeback_queue #(
  parameter int DEPTH      = 4,
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_res,
  input  logic [REG_ADDR_W-1:0]   in_rd,
  input  logic                    in_zero,
  input  logic                    in_neg,
  input  logic                    in_nan,
  output logic                    wb_valid,
  input  logic                    wb_ready,
  output logic [REG_ADDR_W-1:0]   wb_addr,
  output logic [DATA_W-1:0]       wb_data,
  output logic                    flag_zero,
  output logic                    flag_neg,
  output logic                    flag_nan,
  input  logic [REG_ADDR_W-1:0]   lookup_addr,
  output logic                    lookup_hit,
  output logic [DATA_W-1:0]       lookup_data,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [DATA_W-1:0]     data_q [DEPTH];
  logic [REG_ADDR_W-1:0] rd_q   [DEPTH];
  logic [PW-1:0]         head, tail;
  logic                  push, store, pop;
  assign wb_valid = count != '0;
  assign pop      = wb_valid && wb_ready;
  assign in_ready = (count < CW'(DEPTH)) || pop;
  assign push     = in_valid && in_ready;
  // writes to register 0 only update the flags
  assign store    = push && in_rd != '0;
  assign wb_addr  = wb_valid ? rd_q[head] : '0;
  assign wb_data  = wb_valid ? data_q[head] : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      flag_zero <= 1'b0;
      flag_neg  <= 1'b0;
      flag_nan  <= 1'b0;
    end else begin
      if (pop) head <= head + 1'b1;
      if (store) tail <= tail + 1'b1;
      count <= count + CW'(store) - CW'(pop);
      if (push) {flag_zero, flag_neg, flag_nan} <= {in_zero, in_neg, in_nan};
    end
  end
  always_ff @(posedge clk) begin
    if (store) begin
      data_q[tail] <= in_res;
      rd_q[tail]   <= in_rd;
    end
  end
  // scan oldest to youngest so the youngest match wins
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count && lookup_addr != '0 && rd_q[head + PW'(i)] == lookup_addr) begin
        lookup_hit  = 1'b1;
        lookup_data = data_q[head + PW'(i)];
      end
    end
  end
endmodule

// File: tb/tb_alu_writeback_queue.sv
// tb_alu_writeback_queue: randomized scoreboard bench against a queue-based reference model
module tb_alu_writeback_queue;
  localparam int DEPTH = 4;
  localparam int DW = 32;
  localparam int AW = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic [DW-1:0] in_res = '0;
  logic [AW-1:0] in_rd = '0;
  logic in_zero = 1'b0, in_neg = 1'b0, in_nan = 1'b0;
  logic wb_valid, wb_ready = 1'b0;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic flag_zero, flag_neg, flag_nan;
  logic [AW-1:0] lookup_addr = 5;
  logic lookup_hit;
  logic [DW-1:0] lookup_data;
  logic [$clog2(DEPTH):0] count;

  alu_writeback_queue #(.DEPTH(DEPTH), .DATA_W(DW), .REG_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_res(in_res),
    .in_rd(in_rd), .in_zero(in_zero), .in_neg(in_neg), .in_nan(in_nan),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .flag_zero(flag_zero), .flag_neg(flag_neg), .flag_nan(flag_nan),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] rd; logic [DW-1:0] d; } ent_t;
  ent_t sb[$];
  logic [2:0] mflags = '0;
  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: compares pre-edge outputs against the model and retires popped entries
  initial begin
    bit eh, epop;
    logic [DW-1:0] ed;
    ent_t e;
    forever begin
      @(negedge clk);
      #4;
      if (!rst) begin
        epop = sb.size() != 0 && wb_ready;
        chk("count", count, sb.size());
        chk("wb_valid", wb_valid, sb.size() != 0);
        chk("in_ready", in_ready, sb.size() < DEPTH || epop);
        chk("flags", {flag_zero, flag_neg, flag_nan}, mflags);
        eh = 1'b0;
        ed = '0;
        for (int i = sb.size() - 1; i >= 0; i--)
          if (!eh && lookup_addr != 0 && sb[i].rd == lookup_addr) begin
            eh = 1'b1;
            ed = sb[i].d;
          end
        chk("lookup_hit", lookup_hit, eh);
        chk("lookup_data", lookup_data, ed);
        if (epop) begin
          e = sb.pop_front();
          chk("wb_addr", wb_addr, e.rd);
          chk("wb_data", wb_data, e.d);
        end else if (sb.size() == 0) begin
          chk("wb_addr_empty", wb_addr, 0);
          chk("wb_data_empty", wb_data, 0);
        end
      end
    end
  end

  // stimulus: drives random traffic and pushes accepted results into the scoreboard
  initial begin
    bit pend;
    ent_t pe;
    logic [2:0] pf;
    int pv, pr;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (c == 400) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_count", count, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_flags", {flag_zero, flag_neg, flag_nan}, 0);
        chk("rst_lookup_hit", lookup_hit, 0);
        sb.delete();
        mflags = '0;
        @(negedge clk);
        rst = 1'b0;
      end
      pv = c < 200 ? 80 : 50;
      pr = c < 100 ? 15 : (c < 250 ? 50 : 85);
      in_valid = $urandom_range(99) < pv;
      wb_ready = $urandom_range(99) < pr;
      if (c >= 394 && c < 400) begin
        in_valid = 1'b1;
        wb_ready = 1'b0;
      end
      in_rd = AW'($urandom_range(7));
      in_res = $urandom;
      {in_zero, in_neg, in_nan} = 3'($urandom);
      lookup_addr = AW'($urandom_range(7));
      pend = in_valid && (sb.size() < DEPTH || (sb.size() != 0 && wb_ready));
      pe = '{in_rd, in_res};
      pf = {in_zero, in_neg, in_nan};
      @(posedge clk);
      if (pend) begin
        mflags = pf;
        if (pe.rd != 0) sb.push_back(pe);
      end
    end
    @(negedge clk);
    #5;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
